// File: rtl/regfile_sb_pkg.sv
// Shared defaults and encodings for the register file with busy scoreboard.
package regfile_sb_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 3;

  localparam int R0          = 0;
  localparam int RET_REG_DEF = 3;

  localparam logic IDLE = 1'b0;
  localparam logic PEND = 1'b1;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: hardwired zero, write bypass, busy lookup.
module regfile_sb_rdport
  import regfile_sb_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic [AW-1:0]          raddr,
  input  logic [(2**AW)*DW-1:0]  regs_flat,
  input  logic [2**AW-1:0]       busy,
  input  logic                   wen,
  input  logic [AW-1:0]          waddr,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic                   rbusy
);

  always_comb begin
    rdata = regs_flat[int'(raddr)*DW +: DW];
    rbusy = (busy[raddr] == PEND);
    if (ZERO_R0 && int'(raddr) == R0) begin
      rdata = '0;
      rbusy = 1'b0;
    end else if (BYPASS && wen && waddr == raddr) begin
      rdata = wdata;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NREAD read ports, one write port and a per-register
// busy scoreboard set at issue and cleared at writeback.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int NREAD   = 2,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1,
  parameter int RET_REG = RET_REG_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREAD*AW-1:0] raddr,
  output logic [NREAD*DW-1:0] rdata,
  output logic [NREAD-1:0]    rbusy,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [DW-1:0]       wdata,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_ready,
  output logic [2**AW-1:0]    busy_vec,
  output logic [DW-1:0]       ret_val
);

  localparam int NREG = 2**AW;
  localparam logic [AW-1:0] RET_IDX = AW'(RET_REG);

  logic [DW-1:0]      regs_q [NREG];
  logic [DW-1:0]      regs_d [NREG];
  logic [NREG-1:0]    busy_q;
  logic [NREG-1:0]    busy_d;
  logic [NREG*DW-1:0] regs_flat;
  logic               wr_ok;

  assign wr_ok = wen && !(ZERO_R0 && int'(waddr) == R0);

  always_comb begin
    for (int k = 0; k < NREG; k++) regs_d[k] = regs_q[k];
    if (wr_ok) regs_d[waddr] = wdata;
  end

  assign iss_ready = (ZERO_R0 && int'(iss_addr) == R0)
                   ? 1'b1
                   : (busy_q[iss_addr] == IDLE);

  // A new issue supersedes a same-cycle writeback to the same register.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NREG; k++) begin
      if (iss_en && iss_ready && iss_addr == AW'(k)
          && !(ZERO_R0 && k == R0))
        busy_d[k] = PEND;
      else if (wen && waddr == AW'(k))
        busy_d[k] = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
      busy_q <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= regs_d[k];
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[g*DW +: DW] = regs_q[g];
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    regfile_sb_rdport #(
      .DW      (DW),
      .AW      (AW),
      .ZERO_R0 (ZERO_R0),
      .BYPASS  (BYPASS)
    ) u_rd (
      .raddr     (raddr[i*AW +: AW]),
      .regs_flat (regs_flat),
      .busy      (busy_q),
      .wen       (wen),
      .waddr     (waddr),
      .wdata     (wdata),
      .rdata     (rdata[i*DW +: DW]),
      .rbusy     (rbusy[i])
    );
  end

  assign busy_vec = busy_q;
  assign ret_val  = (ZERO_R0 && RET_REG == R0) ? '0 : regs_q[RET_IDX];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb, with a second BYPASS=0 instance.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [5:0]  raddr;
  logic [31:0] rdata, rdata_nb;
  logic [1:0]  rbusy, rbusy_nb;
  logic        wen;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        iss_en;
  logic [2:0]  iss_addr;
  logic        iss_ready, iss_ready_nb;
  logic [7:0]  busy_vec, busy_vec_nb;
  logic [15:0] ret_val, ret_val_nb;

  int n_cmp;
  int n_fail;

  regfile_sb u_dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata),
    .rbusy(rbusy), .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .busy_vec(busy_vec), .ret_val(ret_val)
  );

  regfile_sb #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_nb),
    .rbusy(rbusy_nb), .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready_nb),
    .busy_vec(busy_vec_nb), .ret_val(ret_val_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0;
    iss_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raddr = 6'o32;
    idle();
    waddr = 3'd0; wdata = 16'h0; iss_addr = 3'd5;
    step(); step();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got %h want 00000000", rdata);
    end
    n_cmp++;
    if (busy_vec !== 8'h00 || iss_ready !== 1'b1 || rbusy !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_busy got bv=%h ir=%b rb=%b want 00/1/00",
               busy_vec, iss_ready, rbusy);
    end
    wen = 1'b1; waddr = 3'd3; wdata = 16'h1234;
    iss_en = 1'b1; iss_addr = 3'd5;
    step();
    idle();
    #1;
    n_cmp++;
    if (ret_val !== 16'h1234 || busy_vec !== 8'h20) begin
      n_fail++;
      $display("FAIL pre_reset got rv=%h bv=%h want 1234/20", ret_val, busy_vec);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ret_val !== 16'h0 || busy_vec !== 8'h00 || iss_ready !== 1'b1
        || rdata[15:0] !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset got rv=%h bv=%h ir=%b rd0=%h want 0/0/1/0",
               ret_val, busy_vec, iss_ready, rdata[15:0]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    step();
    wen = 1'b1; waddr = 3'd2; wdata = 16'hBEEF;
    raddr = 6'o00;
    step();
    idle();
    raddr[2:0] = 3'd2;
    #1;
    n_cmp++;
    if (rdata[15:0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL write_read got %h want beef", rdata[15:0]);
    end
    wen = 1'b1; waddr = 3'd0; wdata = 16'hFFFF;
    raddr[2:0] = 3'd0;
    #1;
    n_cmp++;
    if (rdata[15:0] !== 16'h0) begin
      n_fail++; $display("FAIL r0_bypass got %h want 0000", rdata[15:0]);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if (rdata[15:0] !== 16'h0 || rdata_nb[15:0] !== 16'h0) begin
      n_fail++;
      $display("FAIL r0_write got %h/%h want 0000", rdata[15:0], rdata_nb[15:0]);
    end
  endtask

  task automatic test_bypass();
    wen = 1'b1; waddr = 3'd4; wdata = 16'h00A5;
    raddr = {3'd4, 3'd2};
    #1;
    n_cmp++;
    if (rdata[31:16] !== 16'h00A5 || rbusy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass got %h want 00a5", rdata[31:16]);
    end
    n_cmp++;
    if (rdata_nb[31:16] !== 16'h0000) begin
      n_fail++;
      $display("FAIL no_bypass got %h want 0000", rdata_nb[31:16]);
    end
    n_cmp++;
    if (rdata[15:0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL port_indep got %h want beef", rdata[15:0]);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if (rdata[31:16] !== 16'h00A5 || rdata_nb[31:16] !== 16'h00A5) begin
      n_fail++;
      $display("FAIL bypass_stored got %h/%h want 00a5",
               rdata[31:16], rdata_nb[31:16]);
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_addr = 3'd6;
    #1;
    n_cmp++;
    if (iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL issue_ready got %b want 1", iss_ready);
    end
    step();
    idle();
    raddr = {3'd6, 3'd6};
    #1;
    n_cmp++;
    if (busy_vec !== 8'h40 || rbusy !== 2'b11) begin
      n_fail++;
      $display("FAIL issue_busy got bv=%h rb=%b want 40/11", busy_vec, rbusy);
    end
    iss_en = 1'b1; iss_addr = 3'd6;
    #1;
    n_cmp++;
    if (iss_ready !== 1'b0) begin
      n_fail++; $display("FAIL waw_ready got %b want 0", iss_ready);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if (busy_vec !== 8'h40) begin
      n_fail++; $display("FAIL waw_ignored got %h want 40", busy_vec);
    end
    wen = 1'b1; waddr = 3'd6; wdata = 16'h1111;
    #1;
    n_cmp++;
    if (iss_ready !== 1'b0 || rbusy !== 2'b00 || rdata !== 32'h11111111) begin
      n_fail++;
      $display("FAIL wb_same_cycle got ir=%b rb=%b rd=%h want 0/00/11111111",
               iss_ready, rbusy, rdata);
    end
    n_cmp++;
    if (rbusy_nb !== 2'b11) begin
      n_fail++; $display("FAIL wb_nb_busy got %b want 11", rbusy_nb);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if (busy_vec !== 8'h00 || iss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_clear got bv=%h ir=%b want 00/1", busy_vec, iss_ready);
    end
    iss_en = 1'b1; iss_addr = 3'd0;
    step();
    idle();
    #1;
    n_cmp++;
    if (busy_vec !== 8'h00 || iss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_r0 got bv=%h ir=%b want 00/1", busy_vec, iss_ready);
    end
  endtask

  task automatic test_simul_iss_wb();
    iss_en = 1'b1; iss_addr = 3'd1;
    wen = 1'b1; waddr = 3'd1; wdata = 16'h5555;
    step();
    idle();
    raddr = {3'd1, 3'd1};
    #1;
    n_cmp++;
    if (busy_vec !== 8'h02 || rdata !== 32'h55555555 || rbusy !== 2'b11) begin
      n_fail++;
      $display("FAIL iss_wb got bv=%h rd=%h rb=%b want 02/55555555/11",
               busy_vec, rdata, rbusy);
    end
    wen = 1'b1; waddr = 3'd1; wdata = 16'h5555;
    step();
    idle();
  endtask

  task automatic test_ret_val();
    wen = 1'b1; waddr = 3'd3; wdata = 16'h7FFF;
    #1;
    n_cmp++;
    if (ret_val !== 16'h0000) begin
      n_fail++; $display("FAIL ret_pre got %h want 0000", ret_val);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if (ret_val !== 16'h7FFF) begin
      n_fail++; $display("FAIL ret_write got %h want 7fff", ret_val);
    end
    wen = 1'b1; waddr = 3'd3; wdata = 16'h0001;
    #1;
    n_cmp++;
    if (ret_val !== 16'h7FFF) begin
      n_fail++; $display("FAIL ret_no_bypass got %h want 7fff", ret_val);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if (ret_val !== 16'h0001) begin
      n_fail++; $display("FAIL ret_update got %h want 0001", ret_val);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_simul_iss_wb();
    test_ret_val();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
